// File: rtl/hamming_decoder.sv
`default_nettype none
// hamming_decoder: two-stage SECDED decoder for right-aligned 8/16/32-bit codewords
// (odd-weight column code) with valid/ready on both sides and saturating error counters.
module hamming_decoder #(
    parameter int AMBA_WORD = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           CODEWORD_WIDTH,
    input  logic [AMBA_WORD-1:0] DATA_IN,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [AMBA_WORD-1:0] DATA_OUT,
    output logic [1:0]           NUM_OF_ERRORS,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 cnt_clear,
    output logic [CNT_WIDTH-1:0] single_err_cnt,
    output logic [CNT_WIDTH-1:0] double_err_cnt
);

    // Data bit i uses the i-th largest odd-weight (>=3) value that fits in the parity width,
    // so every column has odd weight and any double error yields an even, nonzero syndrome.
    function automatic logic [155:0] build_cols(input int pw, input int nd);
        logic [155:0] t;
        int           k;
        int           ones;
        t = '0;
        k = 0;
        for (int v = 63; v > 0; v--) begin
            ones = 0;
            for (int b = 0; b < 6; b++) ones += (v >> b) & 1;
            if (v < (1 << pw) && k < nd && ones >= 3 && (ones % 2) == 1) begin
                t[k*6 +: 6] = v[5:0];
                k++;
            end
        end
        return t;
    endfunction

    localparam logic [155:0] COLS8  = build_cols(4, 4);
    localparam logic [155:0] COLS16 = build_cols(5, 11);
    localparam logic [155:0] COLS32 = build_cols(6, 26);

    function automatic logic [5:0] calc_syn(input logic [AMBA_WORD-1:0] cw, input int pw,
                                            input int nd, input logic [155:0] cols);
        logic [5:0] s;
        s = '0;
        for (int j = 0; j < pw; j++) s[j] = cw[j];
        for (int i = 0; i < nd; i++) if (cw[pw+i]) s = s ^ cols[i*6 +: 6];
        return s;
    endfunction

    function automatic logic [AMBA_WORD-1:0] flip_mask(input logic [5:0] syn, input int pw,
                                                       input int nd, input logic [155:0] cols);
        logic [AMBA_WORD-1:0] m;
        logic [5:0]           unit;
        m = '0;
        for (int i = 0; i < nd; i++) if (syn == cols[i*6 +: 6]) m[pw+i] = 1'b1;
        for (int j = 0; j < pw; j++) begin
            unit    = '0;
            unit[j] = 1'b1;
            if (syn == unit) m[j] = 1'b1;
        end
        return m;
    endfunction

    logic                 s1_valid_q, s1_valid_d;
    logic [AMBA_WORD-1:0] s1_cw_q, s1_cw_d;
    logic [1:0]           s1_w_q, s1_w_d;
    logic [5:0]           s1_syn_q, s1_syn_d;
    logic                 out_valid_q, out_valid_d;
    logic [AMBA_WORD-1:0] data_out_q, data_out_d;
    logic [1:0]           nerr_q, nerr_d;
    logic [CNT_WIDTH-1:0] single_q, single_d;
    logic [CNT_WIDTH-1:0] double_q, double_d;

    logic                 s2_load;
    logic                 accept;
    logic                 xfer;
    logic [AMBA_WORD-1:0] mask;
    logic [AMBA_WORD-1:0] corr;
    logic [AMBA_WORD-1:0] dec_data;
    logic [1:0]           dec_nerr;

    assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s2_load;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_cw_d    = s1_cw_q;
        s1_w_d     = s1_w_q;
        s1_syn_d   = s1_syn_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_cw_d    = DATA_IN;
            s1_w_d     = CODEWORD_WIDTH;
            case (CODEWORD_WIDTH)
                2'b00:   s1_syn_d = calc_syn(DATA_IN, 4, 4, COLS8);
                2'b01:   s1_syn_d = calc_syn(DATA_IN, 5, 11, COLS16);
                default: s1_syn_d = calc_syn(DATA_IN, 6, 26, COLS32);
            endcase
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        mask     = '0;
        dec_data = '0;
        case (s1_w_q)
            2'b00:   mask = flip_mask(s1_syn_q, 4, 4, COLS8);
            2'b01:   mask = flip_mask(s1_syn_q, 5, 11, COLS16);
            default: mask = flip_mask(s1_syn_q, 6, 26, COLS32);
        endcase
        // On a double error the mask is empty, so the raw data passes through.
        corr = s1_cw_q ^ mask;
        case (s1_w_q)
            2'b00:   dec_data = (corr >> 4) & 32'h0000_000F;
            2'b01:   dec_data = (corr >> 5) & 32'h0000_07FF;
            default: dec_data = (corr >> 6) & 32'h03FF_FFFF;
        endcase
        if (s1_syn_q == 6'd0)  dec_nerr = 2'd0;
        else if (|mask)        dec_nerr = 2'd1;
        else                   dec_nerr = 2'd2;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;
        nerr_d      = nerr_q;
        if (s2_load) begin
            out_valid_d = 1'b1;
            data_out_d  = dec_data;
            nerr_d      = dec_nerr;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        single_d = single_q;
        double_d = double_q;
        if (cnt_clear) begin
            single_d = '0;
            double_d = '0;
        end else if (xfer) begin
            if (nerr_q == 2'd1 && !(&single_q)) single_d = single_q + 1'b1;
            if (nerr_q == 2'd2 && !(&double_q)) double_d = double_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_cw_q     <= '0;
            s1_w_q      <= '0;
            s1_syn_q    <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            nerr_q      <= '0;
            single_q    <= '0;
            double_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_cw_q     <= s1_cw_d;
            s1_w_q      <= s1_w_d;
            s1_syn_q    <= s1_syn_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            nerr_q      <= nerr_d;
            single_q    <= single_d;
            double_q    <= double_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign DATA_OUT       = data_out_q;
    assign NUM_OF_ERRORS  = nerr_q;
    assign single_err_cnt = single_q;
    assign double_err_cnt = double_q;

endmodule
`default_nettype wire

// File: tb/tb_hamming_decoder.sv
`default_nettype none
// tb_hamming_decoder: randomized self-checking bench for hamming_decoder against an
// encoder model plus known injected flips.
module tb_hamming_decoder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  cw_width;
    logic [31:0] data_in;
    logic        in_valid, in_ready;
    logic [31:0] data_out;
    logic [1:0]  nerr;
    logic        out_valid, out_ready, cnt_clear;
    logic [15:0] scnt, dcnt;

    logic [1:0]  s_width;
    logic [31:0] s_data_in;
    logic        s_in_valid, s_in_ready;
    logic [31:0] s_data_out;
    logic [1:0]  s_nerr;
    logic        s_out_valid, s_out_ready, s_cnt_clear;
    logic [3:0]  s_scnt, s_dcnt;

    int checks = 0;
    int errors = 0;

    hamming_decoder #(.AMBA_WORD(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .CODEWORD_WIDTH(cw_width), .DATA_IN(data_in),
        .in_valid(in_valid), .in_ready(in_ready), .DATA_OUT(data_out),
        .NUM_OF_ERRORS(nerr), .out_valid(out_valid), .out_ready(out_ready),
        .cnt_clear(cnt_clear), .single_err_cnt(scnt), .double_err_cnt(dcnt)
    );

    // Narrow counters so saturation is reachable in a few cycles.
    hamming_decoder #(.AMBA_WORD(32), .CNT_WIDTH(4)) dut_s (
        .clk(clk), .rst(rst), .CODEWORD_WIDTH(s_width), .DATA_IN(s_data_in),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .DATA_OUT(s_data_out),
        .NUM_OF_ERRORS(s_nerr), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .cnt_clear(s_cnt_clear), .single_err_cnt(s_scnt), .double_err_cnt(s_dcnt)
    );

    function automatic void geom(input logic [1:0] w, output int pw, output int nd);
        if (w == 2'b00)      begin pw = 4; nd = 4;  end
        else if (w == 2'b01) begin pw = 5; nd = 11; end
        else                 begin pw = 6; nd = 26; end
    endfunction

    // Team encoder: data bit i takes the i-th largest odd-weight (>=3) parity pattern.
    function automatic logic [31:0] encode(input logic [31:0] data, input logic [1:0] w);
        int          pw, nd;
        int          cols[$];
        logic [31:0] par, dm;
        geom(w, pw, nd);
        for (int v = (1 << pw) - 1; v > 0; v--)
            if ($countones(v) >= 3 && ($countones(v) % 2) == 1) cols.push_back(v);
        par = '0;
        for (int i = 0; i < nd; i++) if (data[i]) par = par ^ 32'(cols[i]);
        dm = data & ((32'd1 << nd) - 32'd1);
        return (dm << pw) | par;
    endfunction

    task automatic gen_word(output logic [31:0] cw, output logic [1:0] w,
                            output logic [31:0] exp_d, output logic [1:0] exp_e);
        int pw, nd, nf, p0, p1;
        w = 2'($urandom_range(0, 3));
        geom(w, pw, nd);
        exp_d = $urandom() & ((32'd1 << nd) - 32'd1);
        cw    = encode(exp_d, w);
        nf    = $urandom_range(0, 2);
        p0    = $urandom_range(0, pw + nd - 1);
        p1    = (p0 + $urandom_range(1, pw + nd - 1)) % (pw + nd);
        if (nf >= 1) cw[p0] = ~cw[p0];
        if (nf == 2) begin
            cw[p1] = ~cw[p1];
            exp_d  = (cw >> pw) & ((32'd1 << nd) - 32'd1);
        end
        exp_e = 2'(nf);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || data_out !== 32'd0 || nerr !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h err=%0d expected 0/0/0", out_valid, data_out, nerr);
        end
        checks++;
        if (scnt !== 16'd0 || dcnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", scnt, dcnt);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_8b_vectors();
        logic [31:0] v_cw[4]    = '{32'hAA, 32'hEA, 32'hAB, 32'hEB};
        logic [31:0] v_d[4]     = '{32'hA, 32'hA, 32'hA, 32'hE};
        logic [1:0]  v_e[4]     = '{2'd0, 2'd1, 2'd1, 2'd2};
        logic [15:0] v_sc[4]    = '{16'd0, 16'd1, 16'd2, 16'd2};
        logic [15:0] v_dc[4]    = '{16'd0, 16'd0, 16'd0, 16'd1};
        out_ready = 1'b1;
        cnt_clear = 1'b1;
        @(posedge clk); #1;
        cnt_clear = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cw_width = 2'b00;
            data_in  = v_cw[k];
            in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL v8_in_ready[%0d]: got %b expected 1", k, in_ready);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            data_in  = '0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL v8_early_valid[%0d]: got %b expected 0", k, out_valid);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || data_out !== v_d[k] || nerr !== v_e[k]) begin
                errors++;
                $display("FAIL v8_word[%0d]: got valid=%b data=%h err=%0d expected 1/%h/%0d",
                         k, out_valid, data_out, nerr, v_d[k], v_e[k]);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || scnt !== v_sc[k] || dcnt !== v_dc[k]) begin
                errors++;
                $display("FAIL v8_counts[%0d]: got valid=%b single=%0d double=%0d expected 0/%0d/%0d",
                         k, out_valid, scnt, dcnt, v_sc[k], v_dc[k]);
            end
        end
    endtask

    task automatic test_sweep(input int n_words, input bit rand_bp);
        logic [31:0] q_d[$];
        logic [1:0]  q_e[$];
        logic [31:0] cw, ed, exp_d;
        logic [1:0]  w, ee, exp_e;
        int          sent, got, last_cyc, stalls, es, edc;
        bit          acc;
        sent = 0; got = 0; last_cyc = -1; stalls = 0; es = 0; edc = 0;
        cnt_clear = 1'b1;
        @(posedge clk); #1;
        cnt_clear = 1'b0;
        gen_word(cw, w, ed, ee);
        data_in = cw; cw_width = w; in_valid = 1'b1;
        for (int cyc = 0; cyc < n_words * 6 + 20 && got < n_words; cyc++) begin
            out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            if (in_valid && !in_ready) stalls++;
            if (out_valid && out_ready) begin
                checks++;
                if (q_d.size() == 0) begin
                    errors++;
                    $display("FAIL sweep_spurious: got an output word expected none outstanding");
                end else begin
                    exp_d = q_d.pop_front();
                    exp_e = q_e.pop_front();
                    if (exp_e == 2'd1) es++;
                    if (exp_e == 2'd2) edc++;
                    if (data_out !== exp_d || nerr !== exp_e) begin
                        errors++;
                        $display("FAIL sweep_word[%0d]: got data=%h err=%0d expected data=%h err=%0d",
                                 got, data_out, nerr, exp_d, exp_e);
                    end
                end
                got++;
                last_cyc = cyc;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                q_d.push_back(ed);
                q_e.push_back(ee);
                sent++;
            end
            @(posedge clk); #1;
            if (acc) begin
                if (sent < n_words) begin
                    gen_word(cw, w, ed, ee);
                    data_in = cw; cw_width = w;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got != n_words) begin
            errors++;
            $display("FAIL sweep_delivered: got %0d words expected %0d", got, n_words);
        end
        if (!rand_bp) begin
            checks++;
            if (stalls != 0 || last_cyc != n_words + 1) begin
                errors++;
                $display("FAIL sweep_throughput: got stalls=%0d last=%0d expected 0/%0d", stalls, last_cyc, n_words + 1);
            end
        end
        checks++;
        if (scnt !== 16'(es) || dcnt !== 16'(edc)) begin
            errors++;
            $display("FAIL sweep_counts: got %0d/%0d expected %0d/%0d", scnt, dcnt, es, edc);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] cws[3];
        logic [31:0] exp[3];
        logic [31:0] held;
        int          sent, got, unstable;
        bit          hold_chk;
        sent = 0; got = 0; unstable = 0; hold_chk = 1'b0; held = '0;
        for (int i = 0; i < 3; i++) begin
            exp[i] = $urandom() & 32'h03FF_FFFF;
            cws[i] = encode(exp[i], 2'b10);
        end
        cw_width = 2'b10; data_in = cws[0]; in_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
            out_ready = (cyc >= 5);
            @(negedge clk);
            if (cyc == 4) begin
                checks++;
                if (sent != 2 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_stall: got accepts=%0d in_ready=%b expected 2/0", sent, in_ready);
                end
                checks++;
                if (out_valid !== 1'b1 || data_out !== exp[0]) begin
                    errors++;
                    $display("FAIL bp_head: got valid=%b data=%h expected 1/%h", out_valid, data_out, exp[0]);
                end
            end
            if (hold_chk && (out_valid !== 1'b1 || data_out !== held)) unstable++;
            hold_chk = out_valid && !out_ready;
            held     = data_out;
            if (out_valid && out_ready) begin
                checks++;
                if (data_out !== exp[got] || nerr !== 2'd0) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got data=%h err=%0d expected %h/0", got, data_out, nerr, exp[got]);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
            if (sent < 3) data_in = cws[sent];
            else          in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 3 || unstable != 0) begin
            errors++;
            $display("FAIL bp_drain: got delivered=%0d unstable=%0d expected 3/0", got, unstable);
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] d;
        out_ready = 1'b0; cw_width = 2'b10; in_valid = 1'b1;
        data_in = encode(32'h0000_0123, 2'b10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_prefill: got valid=%b in_ready=%b expected 1/0", out_valid, in_ready);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || data_out !== 32'd0 || nerr !== 2'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_async: got valid=%b data=%h err=%0d in_ready=%b expected 0/0/0/1",
                     out_valid, data_out, nerr, in_ready);
        end
        checks++;
        if (scnt !== 16'd0 || dcnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_async_counts: got %0d/%0d expected 0/0", scnt, dcnt);
        end
        @(posedge clk); #3;
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_discard: got valid=%b expected 0", out_valid);
        end
        d = 32'h02AB_CDEF;
        data_in = encode(d, 2'b11) ^ 32'h0000_1000;
        cw_width = 2'b11; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || data_out !== d || nerr !== 2'd1) begin
            errors++;
            $display("FAIL rst_resume: got valid=%b data=%h err=%0d expected 1/%h/1", out_valid, data_out, nerr, d);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        s_width = 2'b00; s_out_ready = 1'b1; s_cnt_clear = 1'b0;
        s_data_in = 32'hEA; s_in_valid = 1'b1;
        repeat (15) @(posedge clk);
        #1 s_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (s_scnt !== 4'hF) begin
            errors++;
            $display("FAIL sat_reach: got %0d expected 15", s_scnt);
        end
        s_in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 s_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (s_scnt !== 4'hF) begin
            errors++;
            $display("FAIL sat_hold: got %0d expected 15", s_scnt);
        end
        s_data_in = 32'hEB; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (s_dcnt !== 4'd1 || s_scnt !== 4'hF) begin
            errors++;
            $display("FAIL sat_double: got %0d/%0d expected 15/1", s_scnt, s_dcnt);
        end
        s_data_in = 32'hAB; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (s_out_valid !== 1'b1 || s_nerr !== 2'd1) begin
            errors++;
            $display("FAIL sat_pending: got valid=%b err=%0d expected 1/1", s_out_valid, s_nerr);
        end
        s_cnt_clear = 1'b1;
        @(posedge clk); #1;
        s_cnt_clear = 1'b0;
        checks++;
        if (s_scnt !== 4'd0 || s_dcnt !== 4'd0) begin
            errors++;
            $display("FAIL sat_clear_wins: got %0d/%0d expected 0/0", s_scnt, s_dcnt);
        end
    endtask

    initial begin
        rst = 1'b0; cw_width = '0; data_in = '0; in_valid = 1'b0;
        out_ready = 1'b1; cnt_clear = 1'b0;
        s_width = '0; s_data_in = '0; s_in_valid = 1'b0; s_out_ready = 1'b1; s_cnt_clear = 1'b0;
        test_reset();
        test_8b_vectors();
        test_sweep(60, 1'b0);
        test_sweep(60, 1'b1);
        test_backpressure();
        test_sweep(30, 1'b0);
        test_reset_midflight();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
